// File: rtl/booth_seq_ctrl.sv
// booth_seq_ctrl: radix-2 Booth sequential signed multiplier, one recoding step per cycle
module booth_seq_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [WIDTH-1:0]   M,
  input  logic [WIDTH-1:0]   Q,
  output logic [2*WIDTH-1:0] A,
  output logic               busy,
  output logic               done
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  localparam int CW = $clog2(WIDTH + 1);
  state_t state;
  logic [WIDTH:0] acc, sext, sum, sh_acc;
  logic [WIDTH-1:0] mcand, qreg, sh_q;
  logic q_m1, sh_m1;
  logic [CW-1:0] count;
  always_comb begin
    sext = {mcand[WIDTH-1], mcand};
    sum = (qreg[0] & ~q_m1) ? acc - sext : (~qreg[0] & q_m1) ? acc + sext : acc;
    {sh_acc, sh_q, sh_m1} = {sum[WIDTH], sum, qreg};
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state <= IDLE;
      A     <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      acc   <= '0;
      qreg  <= '0;
      q_m1  <= 1'b0;
      count <= '0;
      mcand <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          mcand <= M;
          qreg  <= Q;
          acc   <= '0;
          q_m1  <= 1'b0;
          count <= CW'(WIDTH);
          state <= RUN;
          busy  <= 1'b1;
        end
        RUN: begin
          acc   <= sh_acc;
          qreg  <= sh_q;
          q_m1  <= sh_m1;
          count <= count - 1'b1;
          if (count == CW'(1)) begin
            A     <= {sh_acc[WIDTH-1:0], sh_q};
            state <= DONE;
            done  <= 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
endmodule
